// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit and port encodings, route-stage FSM states,
// and the dimension-ordered next-hop function used by every input port.
package noc_pkg;

    // Coordinate width used by the shared route function; route stages
    // instantiated with a different COORD_W must not use yx_route.
    localparam int COORD_W = 4;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic [2:0] {
        PORT_LOCAL = 3'd0,
        PORT_NORTH = 3'd1,
        PORT_SOUTH = 3'd2,
        PORT_EAST  = 3'd3,
        PORT_WEST  = 3'd4
    } port_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Dimension-ordered next hop. Addresses are {y,x}; compares are unsigned.
    // yx_mode=1 resolves Y first, yx_mode=0 resolves X first.
    function automatic port_e yx_route(input logic [2*COORD_W-1:0] dest,
                                       input logic [2*COORD_W-1:0] cur,
                                       input logic                 yx_mode);
        logic [COORD_W-1:0] dest_y, dest_x, cur_y, cur_x;
        port_e              y_port, x_port;
        dest_y = dest[2*COORD_W-1:COORD_W];
        dest_x = dest[COORD_W-1:0];
        cur_y  = cur[2*COORD_W-1:COORD_W];
        cur_x  = cur[COORD_W-1:0];
        if (dest_y > cur_y)      y_port = PORT_NORTH;
        else if (dest_y < cur_y) y_port = PORT_SOUTH;
        else                     y_port = PORT_LOCAL;
        if (dest_x > cur_x)      x_port = PORT_EAST;
        else if (dest_x < cur_x) x_port = PORT_WEST;
        else                     x_port = PORT_LOCAL;
        if (yx_mode) return (y_port != PORT_LOCAL) ? y_port : x_port;
        else         return (x_port != PORT_LOCAL) ? x_port : y_port;
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// Synchronous FIFO with asynchronous-read storage so a pushed entry is
// visible at data_o right after the push edge. Pointers carry one extra
// wrap bit so full and empty are told apart by the MSB.
module noc_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign data_o  = r_mem[r_rd_ptr[AW-1:0]];

    // Storage write; slots are only read after being written, so no reset.
    always_ff @(posedge clk_i) begin
        if (w_push && !rst_i) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
    end

    // Pointer update; natural overflow gives the modulo 2*DEPTH wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/noc_yx_route_buffer.sv
// Buffered wormhole route stage for one router input port. Head flits are
// routed in dimension order; the route is held until the tail departs.
// Malformed sequences raise a sticky error instead of corrupting routing.
module noc_yx_route_buffer
    import noc_pkg::*;
#(
    parameter int COORD_W = 4,
    parameter int FLIT_W  = 16,
    parameter int DEPTH   = 4,
    parameter bit YX_MODE = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [2*COORD_W-1:0] router_addr_i,
    input  logic [FLIT_W-1:0]    in_flit_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [FLIT_W-1:0]    out_flit_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2:0]           out_port_o,
    output logic                 locked_o,
    output logic                 err_o
);
    logic              w_full;
    logic              w_empty;
    logic              w_fifo_pop;
    logic [FLIT_W-1:0] w_head;
    flit_type_e        w_head_type;
    logic              w_is_start;
    port_e             w_head_route;
    logic              w_fwd;
    logic              w_drop;
    logic              w_err_set;
    state_e            r_state;
    state_e            w_state_next;
    port_e             r_route;
    logic              r_err;

    noc_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (in_valid_i),
        .pop_i   (w_fifo_pop),
        .data_i  (in_flit_i),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign in_ready_o   = !w_full;
    assign out_flit_o   = w_head;
    assign locked_o     = (r_state == ST_LOCKED);
    assign err_o        = r_err;
    assign w_head_type  = flit_type_e'(w_head[FLIT_W-1 -: 2]);
    assign w_is_start   = (w_head_type == FLIT_HEAD) || (w_head_type == FLIT_SINGLE);
    assign w_head_route = yx_route(w_head[2*COORD_W-1:0], router_addr_i, YX_MODE);
    assign w_fwd        = out_valid_o && out_ready_i;
    // Stray body/tail flits in IDLE are discarded without a handshake.
    assign w_fifo_pop   = w_fwd || w_drop;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next state: a forwarded head opens a packet, a forwarded tail closes it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_fwd && w_head_type == FLIT_HEAD) w_state_next = ST_LOCKED;
            ST_LOCKED: if (w_fwd && w_head_type == FLIT_TAIL) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Outputs: handshake, port selection and error/drop detection.
    always_comb begin
        out_valid_o = 1'b0;
        out_port_o  = PORT_LOCAL;
        w_drop      = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    if (w_is_start) begin
                        out_valid_o = 1'b1;
                        out_port_o  = w_head_route;
                    end else begin
                        w_drop    = 1'b1;
                        w_err_set = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                // A new head inside a packet rides the held route as a body.
                out_valid_o = !w_empty;
                out_port_o  = r_route;
                w_err_set   = !w_empty && w_is_start;
            end
            default: ;
        endcase
    end

    // Route capture when a packet head leaves; router address changes later
    // in the packet have no effect.
    always_ff @(posedge clk_i) begin
        if (rst_i)                                                r_route <= PORT_LOCAL;
        else if (r_state == ST_IDLE && w_fwd && w_head_type == FLIT_HEAD) r_route <= w_head_route;
    end

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i)          r_err <= 1'b0;
        else if (w_err_set) r_err <= 1'b1;
    end

endmodule

// File: tb/tb_noc_yx_route_buffer.sv
// Self-checking bench for noc_yx_route_buffer: directed scenarios plus a
// randomized packet stream compared against a queue-based reference model.
module tb_noc_yx_route_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  addr = 8'h02;
    logic [15:0] in_flit = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, locked, err;
    logic [15:0] out_flit;
    logic [2:0]  out_port;
    logic        xy_ready, xy_valid, xy_locked, xy_err;
    logic [15:0] xy_flit;
    logic [2:0]  xy_port;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] mq[$];
    bit          m_locked = 1'b0;
    int          m_port = 0;
    bit          m_err = 1'b0;
    bit          e_valid;
    int          e_port;

    noc_yx_route_buffer #(.COORD_W(4), .FLIT_W(16), .DEPTH(DEPTH), .YX_MODE(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .router_addr_i(addr), .in_flit_i(in_flit),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .out_flit_o(out_flit),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_port_o(out_port),
        .locked_o(locked), .err_o(err));

    noc_yx_route_buffer #(.COORD_W(4), .FLIT_W(16), .DEPTH(DEPTH), .YX_MODE(1'b0)) dut_xy (
        .clk_i(clk), .rst_i(rst), .router_addr_i(addr), .in_flit_i(in_flit),
        .in_valid_i(in_valid), .in_ready_o(xy_ready), .out_flit_o(xy_flit),
        .out_valid_o(xy_valid), .out_ready_i(out_ready), .out_port_o(xy_port),
        .locked_o(xy_locked), .err_o(xy_err));

    initial forever #5 clk = ~clk;

    function automatic int ref_route(input logic [7:0] d, input logic [7:0] c, input bit yx);
        int ny, nx;
        ny = (d[7:4] > c[7:4]) ? 1 : (d[7:4] < c[7:4]) ? 2 : 0;
        nx = (d[3:0] > c[3:0]) ? 3 : (d[3:0] < c[3:0]) ? 4 : 0;
        if (yx) return (ny != 0) ? ny : nx;
        return (nx != 0) ? nx : ny;
    endfunction

    function automatic logic [15:0] mk(input logic [1:0] t, input logic [7:0] d);
        return {t, 6'($urandom), d};
    endfunction

    // Expected handshake/port for the current model state and router address.
    task automatic model_expect();
        logic [1:0] t;
        e_valid = 1'b0;
        e_port  = m_locked ? m_port : 0;
        if (mq.size() > 0) begin
            t = mq[0][15:14];
            if (m_locked) e_valid = 1'b1;
            else if (t == 2'b01 || t == 2'b11) begin
                e_valid = 1'b1;
                e_port  = ref_route(mq[0][7:0], addr, 1'b1);
            end
        end
    endtask

    // Advance the model across one clock edge with the current inputs.
    task automatic model_update();
        int          sz;
        logic [1:0]  t;
        if (rst) begin
            mq.delete(); m_locked = 1'b0; m_port = 0; m_err = 1'b0;
            return;
        end
        sz = mq.size();
        model_expect();
        if (sz > 0) begin
            t = mq[0][15:14];
            if (!m_locked && (t == 2'b00 || t == 2'b10)) begin
                void'(mq.pop_front());
                m_err = 1'b1;
            end else begin
                if (m_locked && (t == 2'b01 || t == 2'b11)) m_err = 1'b1;
                if (out_ready) begin
                    void'(mq.pop_front());
                    if (!m_locked && t == 2'b01) begin m_locked = 1'b1; m_port = e_port; end
                    else if (m_locked && t == 2'b10) m_locked = 1'b0;
                end
            end
        end
        if (in_valid && sz < DEPTH) mq.push_back(in_flit);
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] f);
        in_flit = f; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_flit = mk(2'b11, 8'h02);
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got=%b exp=0", locked); end
        checks++; if (out_port !== 3'd0) begin errors++; $display("FAIL rst_port got=%0d exp=0", out_port); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_flit cyc=%0d got=%b exp=0", i, out_valid); end
        end
        $display("reset: done");
    endtask

    task automatic test_route();
        logic [7:0] dst [3] = '{8'h00, 8'h33, 8'h11};
        logic [7:0] rtr [3] = '{8'h02, 8'h02, 8'h11};
        int         eyx [3] = '{4, 1, 0};
        int         exy [3] = '{4, 3, 0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            addr = rtr[i];
            push(mk(2'b11, dst[i]));
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL route_valid i=%0d got=%b exp=1", i, out_valid); end
            checks++; if (out_port !== 3'(eyx[i])) begin errors++; $display("FAIL route_yx i=%0d got=%0d exp=%0d", i, out_port, eyx[i]); end
            checks++; if (xy_port !== 3'(exy[i])) begin errors++; $display("FAIL route_xy i=%0d got=%0d exp=%0d", i, xy_port, exy[i]); end
            $display("route: rtr=%h dst=%h yx_port=%0d xy_port=%0d", rtr[i], dst[i], out_port, xy_port);
            out_ready = 1'b1; tick(); out_ready = 1'b0;
            checks++; if (out_valid !== 1'b0 || out_port !== 3'd0) begin errors++; $display("FAIL route_idle_port i=%0d got v=%b p=%0d exp v=0 p=0", i, out_valid, out_port); end
        end
        addr = 8'h02;
    endtask

    task automatic test_wormhole();
        logic [15:0] pk [4];
        do_reset(); addr = 8'h02;
        pk[0] = mk(2'b01, 8'h20); pk[1] = mk(2'b00, 8'($urandom));
        pk[2] = mk(2'b00, 8'($urandom)); pk[3] = mk(2'b10, 8'($urandom));
        for (int i = 0; i < 4; i++) push(pk[i]);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL worm_full got=%b exp=0", in_ready); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL worm_prelock got=%b exp=0", locked); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) addr = 8'h33;
            checks++; if (out_valid !== 1'b1 || out_flit !== pk[i]) begin errors++; $display("FAIL worm_flit i=%0d got v=%b f=%h exp v=1 f=%h", i, out_valid, out_flit, pk[i]); end
            checks++; if (out_port !== 3'd1) begin errors++; $display("FAIL worm_port i=%0d got=%0d exp=1", i, out_port); end
            checks++; if (locked !== (i != 0)) begin errors++; $display("FAIL worm_locked i=%0d got=%b exp=%b", i, locked, i != 0); end
            $display("wormhole: flit=%h port=%0d locked=%b", out_flit, out_port, locked);
            tick();
        end
        out_ready = 1'b0;
        checks++; if (locked !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL worm_end got l=%b v=%b exp l=0 v=0", locked, out_valid); end
        addr = 8'h02;
    endtask

    task automatic test_full();
        do_reset(); out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_flit = mk(2'b11, 8'($urandom)); in_valid = 1'b1;
            checks++; if (in_ready !== (i < 4)) begin errors++; $display("FAIL full_ready i=%0d got=%b exp=%b", i, in_ready, i < 4); end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid = (i < 8);
            in_flit  = mk(2'b11, 8'($urandom));
            model_expect();
            checks++; if (in_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL full_ready2 i=%0d got=%b exp=%b", i, in_ready, mq.size() < DEPTH); end
            checks++; if (out_valid !== e_valid) begin errors++; $display("FAIL full_valid i=%0d got=%b exp=%b", i, out_valid, e_valid); end
            if (e_valid) begin
                checks++; if (out_flit !== mq[0] || out_port !== 3'(e_port)) begin errors++; $display("FAIL full_order i=%0d got f=%h p=%0d exp f=%h p=%0d", i, out_flit, out_port, mq[0], e_port); end
                $display("full: pop flit=%h port=%0d", out_flit, out_port);
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_errors();
        do_reset(); addr = 8'h02;
        push(mk(2'b00, 8'h55));
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL err_body_valid got=%b exp=0", out_valid); end
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_body got=%b exp=1", err); end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL err_body_drop got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
        do_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", err); end
        push(mk(2'b01, 8'h20));
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        push(mk(2'b01, 8'h00));
        checks++; if (out_valid !== 1'b1 || out_port !== 3'd1 || locked !== 1'b1) begin errors++; $display("FAIL err_head_fwd got v=%b p=%0d l=%b exp v=1 p=1 l=1", out_valid, out_port, locked); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (err !== 1'b1 || locked !== 1'b1) begin errors++; $display("FAIL err_head got e=%b l=%b exp e=1 l=1", err, locked); end
        push(mk(2'b10, 8'h00));
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (locked !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL err_tail got l=%b e=%b exp l=0 e=1", locked, err); end
        $display("errors: err=%b after stray head", err);
    endtask

    task automatic test_reset_mid();
        do_reset(); addr = 8'h02;
        push(mk(2'b01, 8'h20)); push(mk(2'b00, 8'h01)); push(mk(2'b00, 8'h02));
        out_ready = 1'b1; tick(); tick(); out_ready = 1'b0;
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mid_locked got=%b exp=1", locked); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (locked !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset got l=%b v=%b r=%b exp l=0 v=0 r=1", locked, out_valid, in_ready); end
        push(mk(2'b01, 8'h00));
        checks++; if (out_valid !== 1'b1 || out_port !== 3'd4 || locked !== 1'b0) begin errors++; $display("FAIL mid_fresh got v=%b p=%0d l=%b exp v=1 p=4 l=0", out_valid, out_port, locked); end
        $display("reset_mid: fresh head port=%0d", out_port);
    endtask

    task automatic test_random();
        int          pkt_left = 0;
        logic [15:0] cur;
        bit          acc;
        do_reset();
        cur = mk(2'b11, 8'($urandom));
        for (int cyc = 0; cyc < 800; cyc++) begin
            if ($urandom_range(0, 199) == 0) addr = 8'($urandom);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_flit   = cur;
            model_expect();
            checks++; if (in_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", cyc, in_ready, mq.size() < DEPTH); end
            checks++; if (out_valid !== e_valid) begin errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", cyc, out_valid, e_valid); end
            checks++; if (out_port !== 3'(e_port)) begin errors++; $display("FAIL rnd_port c=%0d got=%0d exp=%0d", cyc, out_port, e_port); end
            checks++; if (locked !== m_locked || err !== m_err) begin errors++; $display("FAIL rnd_state c=%0d got l=%b e=%b exp l=%b e=%b", cyc, locked, err, m_locked, m_err); end
            checks++; if ({xy_valid, xy_ready, xy_locked, xy_err} !== {e_valid, mq.size() < DEPTH, m_locked, m_err}) begin errors++; $display("FAIL rnd_xy_status c=%0d got=%b", cyc, {xy_valid, xy_ready, xy_locked, xy_err}); end
            if (e_valid) begin
                checks++; if (out_flit !== mq[0] || xy_flit !== mq[0]) begin errors++; $display("FAIL rnd_flit c=%0d got=%h/%h exp=%h", cyc, out_flit, xy_flit, mq[0]); end
                if (!m_locked) begin
                    checks++; if (xy_port !== 3'(ref_route(mq[0][7:0], addr, 1'b0))) begin errors++; $display("FAIL rnd_xy_port c=%0d got=%0d exp=%0d", cyc, xy_port, ref_route(mq[0][7:0], addr, 1'b0)); end
                end
            end
            acc = in_valid && (mq.size() < DEPTH);
            tick();
            if (acc) begin
                if (pkt_left == 0) begin
                    if ($urandom_range(0, 2) == 0) cur = mk(2'b11, 8'($urandom));
                    else begin cur = mk(2'b01, 8'($urandom)); pkt_left = $urandom_range(1, 3); end
                end else if (pkt_left == 1) begin
                    cur = mk(2'b10, 8'($urandom)); pkt_left = 0;
                end else begin
                    cur = mk(2'b00, 8'($urandom)); pkt_left--;
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        $display("random: 800 cycles, model queue=%0d", mq.size());
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_route();
        test_wormhole();
        test_full();
        test_errors();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
